alu_exec_unit: RTL and testbench

ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

---
 rtl/alu_ctl_pkg.sv | 26 ++
 rtl/alu_core.sv | 59 +++++
 rtl/alu_exec_unit.sv | 88 ++++++++
 tb/tb_alu_exec_unit.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_ctl_pkg.sv
// rtl/alu_ctl_pkg.sv - ALU control codes and result bundle shared by the decoder and execute unit
//
// Purpose : single source for the 4-bit alu_ctl encodings and the bundle that
//           carries a computed result together with its flags.
// Contents: ALU_W    - width of the result field in alu_res_t (largest WIDTH supported)
//           ALU_*    - alu_ctl code constants
//           alu_res_t- {result, zero, ovf, illegal}
package alu_ctl_pkg;

  localparam int unsigned ALU_W = 32;

  localparam logic [3:0] ALU_AND = 4'd0;
  localparam logic [3:0] ALU_OR  = 4'd1;
  localparam logic [3:0] ALU_ADD = 4'd2;
  localparam logic [3:0] ALU_SUB = 4'd6;
  localparam logic [3:0] ALU_SLT = 4'd7;
  localparam logic [3:0] ALU_NOR = 4'd12;

  typedef struct packed {
    logic [ALU_W-1:0] result;
    logic             zero;
    logic             ovf;
    logic             illegal;
  } alu_res_t;

endpackage

// File: rtl/alu_core.sv
// rtl/alu_core.sv - combinational ALU datapath producing a result bundle
//
// Purpose: evaluate one operation selected by alu_ctl on operands a and b.
// Ports  : alu_ctl [3:0]     in  - operation code (see alu_ctl_pkg)
//          a       [WIDTH]   in  - first operand (rs)
//          b       [WIDTH]   in  - second operand (rt)
//          res     alu_res_t out - result, zero, ovf, illegal
module alu_core
  import alu_ctl_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_W
) (
  input  logic [3:0]       alu_ctl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output alu_res_t         res
);

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] r;
  logic             v;
  logic             ill;

  assign sum  = a + b;
  assign diff = a - b;

  always_comb begin
    r   = '0;
    v   = 1'b0;
    ill = 1'b0;
    case (alu_ctl)
      ALU_AND: r = a & b;
      ALU_OR:  r = a | b;
      ALU_ADD: begin
        r = sum;
        // Same-sign operands whose sum flips sign have wrapped.
        v = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_SUB: begin
        r = diff;
        // Subtracting an opposite-sign value can wrap past the range.
        v = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_SLT: r = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_NOR: r = ~(a | b);
      default: ill = 1'b1;
    endcase
  end

  always_comb begin
    res         = '0;
    res.result  = ALU_W'(r);
    res.zero    = (r == '0);
    res.ovf     = v;
    res.illegal = ill;
  end

endmodule

// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - ALU execute stage with valid/ready handshake and two-entry buffering
//
// Purpose: accept operations, compute them in alu_core and present results
//          with one cycle of latency; an output register plus one skid
//          register absorb downstream stalls without losing throughput.
// Ports  : clk, reset (async, active high)
//          in_valid/in_ready, alu_ctl, op_a, op_b     - operation input
//          out_valid/out_ready, result, zero, ovf,
//          illegal                                    - result output
//          illegal_cnt [CNT_W]                        - saturating count of accepted illegal ops
module alu_exec_unit
  import alu_ctl_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_ctl,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             ovf,
  output logic             illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  alu_res_t         core_res;
  alu_res_t         out_q;
  alu_res_t         skid_q;
  logic             out_valid_q;
  logic             skid_empty_q;
  logic [CNT_W-1:0] illegal_cnt_q;
  logic             accept;
  logic             consume;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .alu_ctl (alu_ctl),
    .a       (op_a),
    .b       (op_b),
    .res     (core_res)
  );

  assign accept  = in_valid & skid_empty_q;
  assign consume = out_valid_q & out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q         <= '0;
      skid_q        <= '0;
      out_valid_q   <= 1'b0;
      skid_empty_q  <= 1'b1;
      illegal_cnt_q <= '0;
    end else begin
      // A full skid blocks accept, so the first branch never sees one.
      if (consume && !skid_empty_q) begin
        out_q        <= skid_q;
        skid_empty_q <= 1'b1;
      end else if (accept && (consume || !out_valid_q)) begin
        out_q       <= core_res;
        out_valid_q <= 1'b1;
      end else if (accept) begin
        skid_q       <= core_res;
        skid_empty_q <= 1'b0;
      end else if (consume) begin
        out_valid_q <= 1'b0;
      end

      if (accept && core_res.illegal && (illegal_cnt_q != {CNT_W{1'b1}})) begin
        illegal_cnt_q <= illegal_cnt_q + CNT_W'(1);
      end
    end
  end

  assign in_ready    = skid_empty_q;
  assign out_valid   = out_valid_q;
  assign result      = out_q.result[WIDTH-1:0];
  assign zero        = out_q.zero;
  assign ovf         = out_q.ovf;
  assign illegal     = out_q.illegal;
  assign illegal_cnt = illegal_cnt_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb/tb_alu_exec_unit.sv - self-checking bench for alu_exec_unit
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, out_ready;
  logic [3:0]  alu_ctl;
  logic [31:0] op_a, op_b;
  logic        in_ready, out_valid, zero, ovf, illegal;
  logic [31:0] result;
  logic [7:0]  illegal_cnt;
  logic [34:0] obs_b;

  logic        in_valid2;
  logic [3:0]  alu_ctl2;
  logic [31:0] op_a2, op_b2;
  logic        in_ready2, out_valid2, zero2, ovf2, illegal2;
  logic [31:0] result2;
  logic [1:0]  illegal_cnt2;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  alu_exec_unit #(.WIDTH(32), .CNT_W(8)) dut (
    .clk(clk), .reset(rst), .in_valid(in_valid), .in_ready(in_ready),
    .alu_ctl(alu_ctl), .op_a(op_a), .op_b(op_b), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .zero(zero), .ovf(ovf),
    .illegal(illegal), .illegal_cnt(illegal_cnt)
  );

  alu_exec_unit #(.WIDTH(32), .CNT_W(2)) dut2 (
    .clk(clk), .reset(rst), .in_valid(in_valid2), .in_ready(in_ready2),
    .alu_ctl(alu_ctl2), .op_a(op_a2), .op_b(op_b2), .out_valid(out_valid2),
    .out_ready(1'b1), .result(result2), .zero(zero2), .ovf(ovf2),
    .illegal(illegal2), .illegal_cnt(illegal_cnt2)
  );

  assign obs_b = {result, zero, ovf, illegal};

  // Reference: true signed arithmetic in 64 bits; overflow is "the exact
  // answer does not survive truncation to 32 signed bits".
  function automatic logic [34:0] model(input logic [3:0] ctl, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, s;
    logic [31:0] r;
    logic v, ill;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    s = 0; r = '0; v = 1'b0; ill = 1'b0;
    case (ctl)
      4'd0:  r = a & b;
      4'd1:  r = a | b;
      4'd2:  begin s = sa + sb; r = 32'(s); v = (s != longint'($signed(r))); end
      4'd6:  begin s = sa - sb; r = 32'(s); v = (s != longint'($signed(r))); end
      4'd7:  r = (sa < sb) ? 32'd1 : 32'd0;
      4'd12: r = ~(a | b);
      default: ill = 1'b1;
    endcase
    return {r, (r == 32'd0), v, ill};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input logic v, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    in_valid = v; alu_ctl = c; op_a = a; op_b = b;
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(5))
      0: return 32'h0000_0000;
      1: return 32'h7fff_ffff;
      2: return 32'h8000_0000;
      3: return 32'hffff_ffff;
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [3:0] pick_ctl();
    case ($urandom_range(7))
      0: return 4'd0;
      1: return 4'd1;
      2: return 4'd2;
      3: return 4'd6;
      4: return 4'd7;
      5: return 4'd12;
      default: return 4'($urandom_range(15));
    endcase
  endfunction

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [34:0] q[$];
    logic [34:0] prev;
    logic        stalled, acc, con;
    int          accepted, consumed, cyc, exp_cnt;
    localparam int N = 10000;

    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; alu_ctl = '0; op_a = '0; op_b = '0;
    in_valid2 = 1'b0; alu_ctl2 = '0; op_a2 = '0; op_b2 = '0;
    #1 rst = 1'b1;
    tick(); tick();

    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_result", result, 32'd0);
    chk("rst_flags", {zero, ovf, illegal}, 3'b000);
    chk("rst_cnt", illegal_cnt, 8'd0);
    #2 rst = 1'b0;

    // Signed overflow on ADD, one cycle latency.
    out_ready = 1'b1;
    apply(1'b1, 4'd2, 32'h7fff_ffff, 32'd1);
    tick();
    chk("add_valid", out_valid, 1'b1);
    chk("add_result", result, 32'h8000_0000);
    chk("add_ovf_zero", {ovf, zero}, 2'b10);
    chk("add_model", obs_b, model(4'd2, 32'h7fff_ffff, 32'd1));
    in_valid = 1'b0;
    tick();
    chk("add_drained", out_valid, 1'b0);

    // Back-to-back SUB, SLT, NOR.
    apply(1'b1, 4'd6, 32'd5, 32'd5);
    tick();
    chk("sub_res", obs_b, {32'd0, 1'b1, 1'b0, 1'b0});
    apply(1'b1, 4'd7, 32'hffff_ffff, 32'd1);
    tick();
    chk("slt_valid", out_valid, 1'b1);
    chk("slt_res", obs_b, {32'd1, 1'b0, 1'b0, 1'b0});
    apply(1'b1, 4'd12, 32'd0, 32'd0);
    tick();
    chk("nor_valid", out_valid, 1'b1);
    chk("nor_res", obs_b, {32'hffff_ffff, 1'b0, 1'b0, 1'b0});
    in_valid = 1'b0;
    tick();
    chk("b2b_drained", out_valid, 1'b0);

    // Stall: two entries fill, third waits for skid to free.
    out_ready = 1'b0;
    apply(1'b1, 4'd2, 32'd10, 32'd20);
    tick();
    chk("stall_a_valid", {out_valid, in_ready}, 2'b11);
    chk("stall_a_res", result, 32'd30);
    apply(1'b1, 4'd0, 32'h0000_f0f0, 32'h0000_ff00);
    tick();
    chk("stall_full", in_ready, 1'b0);
    chk("stall_hold1", result, 32'd30);
    apply(1'b1, 4'd1, 32'd1, 32'd2);
    tick();
    chk("stall_still_full", in_ready, 1'b0);
    chk("stall_hold2", result, 32'd30);
    out_ready = 1'b1;
    tick();
    chk("stall_b_res", result, 32'h0000_f000);
    chk("stall_skid_free", {out_valid, in_ready}, 2'b11);
    tick();
    chk("stall_c_res", result, 32'd3);
    in_valid = 1'b0;
    tick();
    chk("stall_drained", out_valid, 1'b0);

    // Illegal codes still flow and are counted.
    apply(1'b1, 4'd15, 32'h1234, 32'h5678);
    tick();
    chk("ill15", obs_b, {32'd0, 1'b1, 1'b0, 1'b1});
    apply(1'b1, 4'd3, 32'hffff, 32'd1);
    tick();
    chk("ill3", obs_b, {32'd0, 1'b1, 1'b0, 1'b1});
    in_valid = 1'b0;
    tick();
    chk("ill_cnt2", illegal_cnt, 8'd2);

    in_valid2 = 1'b1; alu_ctl2 = 4'd15;
    tick(); tick();
    chk("sat_cnt2", illegal_cnt2, 2'd2);
    tick(); tick(); tick();
    chk("sat_cnt3", illegal_cnt2, 2'd3);
    in_valid2 = 1'b0;

    // Asynchronous reset with both entries full.
    out_ready = 1'b0;
    apply(1'b1, 4'd2, 32'd1, 32'd1);
    tick();
    apply(1'b1, 4'd2, 32'd2, 32'd2);
    tick();
    chk("pre_rst_full", {out_valid, in_ready}, 2'b10);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_state", {out_valid, in_ready}, 2'b01);
    chk("async_rst_data", {illegal_cnt, obs_b}, 43'd0);
    tick();
    chk("no_accept_in_rst", out_valid, 1'b0);
    rst = 1'b0;
    out_ready = 1'b1;
    apply(1'b1, 4'd6, 32'd9, 32'd4);
    tick();
    chk("post_rst_valid", out_valid, 1'b1);
    chk("post_rst_res", obs_b, model(4'd6, 32'd9, 32'd4));
    in_valid = 1'b0;
    tick();
    chk("post_rst_drained", out_valid, 1'b0);

    // Random traffic against a queue-based scoreboard.
    accepted = 0; consumed = 0; cyc = 0; exp_cnt = 0;
    stalled = 1'b0; prev = '0;
    in_valid = 1'b0; out_ready = 1'b0;
    while (consumed < N && cyc < 60000) begin
      chk("rnd_out_valid", out_valid, (q.size() > 0));
      chk("rnd_in_ready", in_ready, (q.size() < 2));
      if (q.size() > 0) chk("rnd_data", obs_b, q[0]);
      if (stalled) chk("rnd_hold", obs_b, prev);

      if (accepted < N) apply(($urandom_range(3) != 0), pick_ctl(), pick_operand(), pick_operand());
      else in_valid = 1'b0;
      out_ready = ($urandom_range(3) != 0);

      acc = in_valid && in_ready;
      con = out_valid && out_ready;
      stalled = out_valid && !out_ready;
      prev = obs_b;
      tick();
      if (con && q.size() > 0) begin
        void'(q.pop_front());
        consumed++;
      end
      if (acc) begin
        q.push_back(model(alu_ctl, op_a, op_b));
        accepted++;
        if (q[q.size()-1][0] && exp_cnt < 255) exp_cnt++;
      end
      cyc++;
    end
    chk("rnd_consumed", consumed, N);
    chk("rnd_accepted", accepted, N);
    chk("rnd_queue_empty", q.size(), 0);
    chk("rnd_illegal_cnt", illegal_cnt, exp_cnt);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
